// File: rtl/mem_stage.sv
// Memory-access stage: data RAM, load extension, alignment faults.
// Registers the W-stage bundle, acting as the MEM/WB pipeline register.
module mem_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RegWriteM,
   input  logic [1:0]            ResultSrcM,
   input  logic                  MemWriteM,
   input  logic [2:0]            funct3M,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   input  logic [4:0]            RdM,
   input  logic [DATA_WIDTH-1:0] PCPlus4M,
   output logic                  RegWriteW,
   output logic [1:0]            ResultSrcW,
   output logic [DATA_WIDTH-1:0] ALUResultW,
   output logic [DATA_WIDTH-1:0] ReadDataW,
   output logic [4:0]            RdW,
   output logic [DATA_WIDTH-1:0] PCPlus4W,
   output logic                  FaultW
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] ram [DEPTH];

   logic [ADDR_WIDTH-1:0] widx;
   logic [1:0]            off;
   logic                  is_ld;
   logic                  is_st;
   logic                  bad;
   logic                  fault;
   logic                  we;
   logic [3:0]            be;
   logic [DATA_WIDTH-1:0] wdata;

   logic [DATA_WIDTH-1:0] raw_q;
   logic [2:0]            f3_q;
   logic [1:0]            off_q;
   logic                  ldf_q;

   logic [7:0]            bsel;
   logic [15:0]           hsel;

   logic                  unused_addr;
   assign unused_addr = ^ALUResultM[DATA_WIDTH-1:ADDR_WIDTH+2];

   always_comb begin
      widx  = ALUResultM[ADDR_WIDTH+1:2];
      off   = ALUResultM[1:0];
      is_st = MemWriteM;
      is_ld = (ResultSrcM == 2'b01) & ~MemWriteM;
   end

   // Lane enables and replicated store data; size comes from funct3[1:0].
   always_comb begin
      bad   = 1'b0;
      be    = 4'b0000;
      wdata = WriteDataM;
      case (funct3M[1:0])
         2'b00: begin
            be    = 4'b0001 << off;
            wdata = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << {off[1], 1'b0};
            wdata = {2{WriteDataM[15:0]}};
            bad   = off[0];
         end
         2'b10: begin
            be    = 4'b1111;
            bad   = |off;
         end
         default: bad = 1'b1;
      endcase
      if (funct3M[2] & funct3M[1])
         bad = 1'b1;
   end

   assign fault = (is_ld | is_st) & bad;
   assign we    = is_st & ~fault & rst;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i])
               ram[widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         ALUResultW <= '0;
         RdW        <= 5'd0;
         PCPlus4W   <= '0;
         FaultW     <= 1'b0;
         raw_q      <= '0;
         f3_q       <= 3'b000;
         off_q      <= 2'b00;
         ldf_q      <= 1'b0;
      end else begin
         RegWriteW  <= RegWriteM & ~(is_ld & fault);
         ResultSrcW <= ResultSrcM;
         ALUResultW <= ALUResultM;
         RdW        <= RdM;
         PCPlus4W   <= PCPlus4M;
         FaultW     <= fault;
         raw_q      <= ram[widx];
         f3_q       <= funct3M;
         off_q      <= off;
         ldf_q      <= is_ld & fault;
      end
   end

   always_comb begin
      bsel = raw_q[8*off_q +: 8];
      hsel = off_q[1] ? raw_q[31:16] : raw_q[15:0];
      case (f3_q)
         3'b000:  ReadDataW = {{24{bsel[7]}}, bsel};
         3'b100:  ReadDataW = {24'd0, bsel};
         3'b001:  ReadDataW = {{16{hsel[15]}}, hsel};
         3'b101:  ReadDataW = {16'd0, hsel};
         default: ReadDataW = raw_q;
      endcase
      if (ldf_q)
         ReadDataW = '0;
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a word-array model and
// a per-cycle compare process.
module tb_mem_stage;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteM;
   logic [1:0]  ResultSrcM;
   logic        MemWriteM;
   logic [2:0]  funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [4:0]  RdM;
   logic [31:0] PCPlus4M;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW;
   logic [31:0] ReadDataW;
   logic [4:0]  RdW;
   logic [31:0] PCPlus4W;
   logic        FaultW;

   mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
      .MemWriteM(MemWriteM), .funct3M(funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .RdM(RdM), .PCPlus4M(PCPlus4M),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
      .RdW(RdW), .PCPlus4W(PCPlus4W), .FaultW(FaultW)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          v;
      logic        rw;
      logic [1:0]  rs;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        flt;
      logic [31:0] rdata;
      bit          chk_rd;
   } exp_t;

   exp_t        ex;
   logic [31:0] mm [int];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (ex.v) begin
         chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, ex.rw});
         chk("ResultSrcW", {30'd0, ResultSrcW}, {30'd0, ex.rs});
         chk("ALUResultW", ALUResultW, ex.alu);
         chk("RdW", {27'd0, RdW}, {27'd0, ex.rd});
         chk("PCPlus4W", PCPlus4W, ex.pc);
         chk("FaultW", {31'd0, FaultW}, {31'd0, ex.flt});
         if (ex.chk_rd)
            chk("ReadDataW", ReadDataW, ex.rdata);
      end
   end

   function automatic logic [31:0] ext(input logic [31:0] w,
                                       input logic [2:0] f3,
                                       input int o);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * o)) & 32'hFF;
      h = (w >> (16 * (o / 2))) & 32'hFFFF;
      case (f3)
         3'd0: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
         3'd4: return b;
         3'd1: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
         3'd5: return h;
         default: return w;
      endcase
   endfunction

   task automatic issue(input bit r, input logic rw,
                        input logic [1:0] rs, input logic mw,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] pc);
      int          w;
      int          o;
      int          nb;
      bit          is_mem;
      bit          is_ld;
      bit          f;
      logic [31:0] word;
      bit          known;
      @(negedge clk);
      rst        = r;
      RegWriteM  = rw;
      ResultSrcM = rs;
      MemWriteM  = mw;
      funct3M    = f3;
      ALUResultM = a;
      WriteDataM = wd;
      RdM        = rd;
      PCPlus4M   = pc;
      ex.v = 1'b1;
      if (!r) begin
         ex.rw = 0; ex.rs = 0; ex.alu = 0; ex.rd = 0;
         ex.pc = 0; ex.flt = 0; ex.rdata = 0; ex.chk_rd = 1'b1;
         return;
      end
      w      = int'((a >> 2) % DEPTH);
      o      = int'(a % 4);
      is_mem = mw || (rs == 2'b01);
      is_ld  = (rs == 2'b01) && !mw;
      f = is_mem && (f3 == 3 || f3 == 6 || f3 == 7 ||
                     ((f3 == 1 || f3 == 5) && (o % 2 == 1)) ||
                     (f3 == 2 && o != 0));
      known = mm.exists(w);
      word  = known ? mm[w] : 32'd0;
      ex.rw     = rw && !(is_ld && f);
      ex.rs     = rs;
      ex.alu    = a;
      ex.rd     = rd;
      ex.pc     = pc;
      ex.flt    = f;
      ex.chk_rd = is_ld && (known || f);
      ex.rdata  = f ? 32'd0 : ext(word, f3, o);
      if (mw && !f) begin
         nb = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
         for (int k = 0; k < nb; k++)
            word[8*(o+k) +: 8] = wd[8*k +: 8];
         mm[w] = word;
      end
   endtask

   task automatic st(input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd);
      issue(1, 0, 2'b00, 1, f3, a, wd, 5'd0, a + 4);
   endtask

   task automatic ld(input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] lit);
      issue(1, 1, 2'b01, 0, f3, a, 32'h5555_AAAA, 5'd3, a + 8);
      chk("model_lit", ex.rdata, lit);
   endtask

   initial begin
      ex = '{default: 0};
      rst = 1'b0;
      RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0; funct3M = 0;
      ALUResultM = 0; WriteDataM = 0; RdM = 0; PCPlus4M = 0;

      for (int i = 0; i < 3; i++)
         issue(0, 1'($urandom), 2'($urandom), 1'($urandom),
               3'($urandom), $urandom, $urandom, 5'($urandom),
               $urandom);

      st(3'd2, 32'h20, 32'h1122_3344);
      issue(0, 0, 2'b00, 1, 3'd2, 32'h20, 32'h9999_9999, 5'd0, 32'h4);
      ld(3'd2, 32'h20, 32'h1122_3344);

      @(negedge clk);
      rst = 1'b0;
      MemWriteM = 1'b0;
      #1;
      chk("async_RegWriteW", {31'd0, RegWriteW}, 32'd0);
      chk("async_ReadDataW", ReadDataW, 32'd0);
      chk("async_PCPlus4W", PCPlus4W, 32'd0);
      ex = '{v: 1, chk_rd: 1, default: 0};

      st(3'd2, 32'h10, 32'hDEAD_BEEF);
      ld(3'd2, 32'h10, 32'hDEAD_BEEF);

      st(3'd0, 32'h13, 32'h0000_0080);
      ld(3'd0, 32'h13, 32'hFFFF_FF80);
      ld(3'd4, 32'h13, 32'h0000_0080);
      ld(3'd2, 32'h10, 32'h80AD_BEEF);

      st(3'd1, 32'h12, 32'h0000_1234);
      ld(3'd1, 32'h12, 32'h0000_1234);
      ld(3'd5, 32'h10, 32'h0000_BEEF);
      ld(3'd1, 32'h10, 32'hFFFF_BEEF);

      st(3'd2, 32'h11, 32'hFFFF_FFFF);
      chk("model_st_fault", {31'd0, ex.flt}, 32'd1);
      ld(3'd2, 32'h10, 32'h1234_BEEF);
      ld(3'd2, 32'h12, 32'h0000_0000);
      chk("model_ld_fault_rw", {31'd0, ex.rw}, 32'd0);
      ld(3'd3, 32'h14, 32'h0000_0000);
      ld(3'd1, 32'h13, 32'h0000_0000);

      st(3'd2, (32'd4 << AW) + 32'h10, 32'hA5A5_A5A5);
      ld(3'd2, 32'h10, 32'hA5A5_A5A5);
      ld(3'd0, 32'h11, 32'hFFFF_FFA5);

      issue(1, 1, 2'b00, 0, 3'd2, 32'h0000_0013, 32'h0, 5'd7,
            32'h104);
      chk("model_alu_fault", {31'd0, ex.flt}, 32'd0);
      issue(1, 1, 2'b10, 0, 3'd7, 32'h0000_0003, 32'h0, 5'd9,
            32'h108);

      @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RV32I pipeline.
- Consumes the M-stage bundle from the EX/MEM register and performs the data-memory access: byte-enabled stores and sign/zero-extended loads.
- Holds the data RAM internally and registers the W-stage bundle, so the block also acts as the MEM/WB pipeline register.
- Also detects misaligned or illegal accesses.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 is supported.
ADDR_WIDTH, 10, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words.

Ports:
clk  input  1  clock; rising edge active.
rst  input  1  asynchronous, active-low reset (asserted when 0).
RegWriteM  input  1  register-file write enable from EX/MEM.
ResultSrcM  input  2  writeback select: 00 = ALU, 01 = memory, 10 = PC+4, 11 = reserved.
MemWriteM  input  1  store enable.
funct3M  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
ALUResultM  input  DATA_WIDTH  byte address for loads/stores; ALU result otherwise.
WriteDataM  input  DATA_WIDTH  store data, right-aligned.
RdM  input  5  destination register.
PCPlus4M  input  DATA_WIDTH  PC+4 of the instruction.
RegWriteW  output  1  registered RegWriteM, forced to 0 on a faulting load.
ResultSrcW  output  2  registered ResultSrcM.
ALUResultW  output  DATA_WIDTH  registered ALUResultM.
ReadDataW  output  DATA_WIDTH  extended load data.
RdW  output  5  registered RdM.
PCPlus4W  output  DATA_WIDTH  registered PCPlus4M.
FaultW  output  1  misaligned or illegal memory access by the instruction now in W.

Behaviour:
- Reset:
  - While rst = 0, all W outputs are 0 asynchronously.
  - Internal raw-word, funct3 and byte-offset registers are 0, so ReadDataW = 0.
  - RAM contents are not reset and are retained across reset.
  - A store presented while rst = 0 is not performed.
- Latency: one cycle. M inputs sampled at edge N appear on the W outputs after edge N.
- Load: ResultSrcM = 01 and MemWriteM = 0.
- Address decode:
  - Word index = ALUResultM[ADDR_WIDTH+1:2]; upper bits are ignored, so addresses wrap modulo RAM size.
  - Byte offset = ALUResultM[1:0].
- Store (MemWriteM = 1, no fault) writes the RAM at the rising edge with byte enables:
  - SB: lane = offset, data = WriteDataM[7:0].
  - SH: lanes offset and offset+1, offset ∈ {0, 2}, data = WriteDataM[15:0].
  - SW: all lanes.
  - Unwritten lanes are unchanged.
- RAM read:
  - Synchronous, every cycle, at the word index.
  - Read-first: a same-edge write to the same word is not visible to that read.
  - A store followed by a load in the next instruction returns the new data.
- ReadDataW is combinational from the registered raw word, registered funct3 and registered offset:
  - LB: bytes selected by offset, sign-extended.
  - LBU: bytes selected by offset, zero-extended.
  - LH: halfword selected by offset[1], sign-extended.
  - LHU: halfword selected by offset[1], zero-extended.
  - LW: whole word.
- Fault conditions, evaluated only for loads or stores:
  - Halfword access with offset[0] = 1.
  - Word access with offset ≠ 00.
  - funct3 ∈ {011, 110, 111}.
- On a fault:
  - Store is suppressed (no RAM change).
  - Load gives ReadDataW = 0 and RegWriteW = 0.
  - FaultW = 1 for exactly that instruction's W cycle.
- Non-memory instructions:
  - FaultW = 0.
  - ReadDataW holds the extension of whatever word was read; it is don't-care but deterministic.
- MemWriteM = 1 together with ResultSrcM = 01 is treated as a store only; the load path flags nothing.
- Reset deasserting mid-stream: the first edge with rst = 1 captures the inputs normally.

Test Plan:
1. Reset with rst = 0 and random inputs → all W outputs 0; a store issued during reset leaves RAM unchanged (a later LW at that address returns the pre-reset value).
2. SW 0xDEADBEEF @0x10, then LW @0x10 next cycle → ReadDataW = 0xDEADBEEF one cycle after the load, RegWriteW = 1, FaultW = 0.
3. SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LW @0x10 → 0x80ADBEEF.
4. SH 0x1234 @0x12, then LH @0x12 → 0x00001234; LHU @0x10 → 0x0000BEEF; LH @0x10 → 0xFFFFBEEF.
5. SW @0x11 → FaultW = 1 next cycle and RAM word 4 unchanged; LW @0x12 → FaultW = 1, ReadDataW = 0, RegWriteW = 0.
6. Address wrap and passthrough:
   - SW 0xA5A5A5A5 @(4 << ADDR_WIDTH)+0x10, then LW @0x10 → 0xA5A5A5A5.
   - An ALU instruction with ResultSrcM = 00, RdM = 7, PCPlus4M = 0x104 → ResultSrcW = 00, RdW = 7, PCPlus4W = 0x104, FaultW = 0.
